// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling, one-cycle
// valid / frame_err pulses, and a RECOVER state that waits out a held-low break.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  state_t      w_state_n;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;

  logic        w_rx;
  logic        w_sample;
  logic        w_load;
  logic        w_ferr;
  logic        w_cnt_clr;

  assign w_rx = r_sync2;

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_sample  = 1'b0;
    w_load    = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx) w_state_n = START;
      end
      START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (r_cnt == HALF_M1) w_state_n = w_rx ? IDLE : DATA;
      end
      DATA: begin
        if (r_cnt == FULL_M1) begin
          w_sample = 1'b1;
          if (r_bit == 3'd7) w_state_n = STOP;
        end
      end
      STOP: begin
        if (r_cnt == FULL_M1) begin
          if (w_rx) begin
            w_load    = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_ferr    = 1'b1;
            w_state_n = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (w_rx) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // The counter only times START/DATA/STOP; it is held at zero while waiting.
  assign w_cnt_clr = (w_state_n != r_state) || w_sample ||
                     (r_state == IDLE) || (r_state == RECOVER);

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_clr ? 16'd0 : 16'(r_cnt + 16'd1);
      if (r_state == START && w_state_n == DATA) begin
        r_bit <= 3'd0;
      end else if (w_sample) begin
        r_bit          <= 3'(r_bit + 3'd1);
        r_shift[r_bit] <= w_rx;
      end
      if (w_load) r_data <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_ferr;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed framing scenarios followed by random frames,
// checked against a byte-queue model of the serial link.
module tb_uart_rx;

  localparam int N = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] exp_q[$];
  int         valid_cyc_q[$];
  logic [7:0] model_data = 8'h00;
  int         ferr_seen  = 0;
  int         exp_ferr   = 0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clkin    (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (N - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int k);
    @(negedge clk);
    k  = cyc + 1;
    rx = 1'b0;
    repeat (N - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // scoreboard: every valid pops the next expected byte; data must hold otherwise
  always @(posedge clk) begin
    #1;
    if (rst) begin
      model_data = 8'h00;
    end else begin
      vectors++;
      if (valid) begin
        valid_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          miscompares++;
          $error("FAIL unexpected_valid: observed data 0x%0h expected no valid", data);
        end else begin
          model_data = exp_q.pop_front();
          assert (data === model_data) else begin
            miscompares++;
            $error("FAIL rx_byte: observed 0x%0h expected 0x%0h", data, model_data);
          end
        end
      end else begin
        assert (data === model_data) else begin
          miscompares++;
          $error("FAIL data_hold: observed 0x%0h expected 0x%0h", data, model_data);
        end
      end
      if (frame_err) ferr_seen++;
      vectors++;
      assert (!(valid && frame_err)) else begin
        miscompares++;
        $error("FAIL pulse_overlap: observed valid=%0b frame_err=%0b expected not both", valid, frame_err);
      end
    end
  end

  initial begin
    int k;
    int k2;
    int busy_cnt;
    int ferr_before;
    int low_busy_miss;
    logic [7:0] b;
    logic err;
    int gap;

    // reset
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // single frame 0x99 and its latency
    valid_cyc_q.delete();
    ferr_before = ferr_seen;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, k);
    idle(4);
    check("single_valid_count", 32'(valid_cyc_q.size()), 32'd1);
    if (valid_cyc_q.size() > 0) check("single_latency", 32'(valid_cyc_q[0]), 32'(k + 154));
    check("single_data", 32'(data), 32'h99);
    check("single_no_ferr", 32'(ferr_seen), 32'(ferr_before));
    check("single_busy_after", 32'(busy), 32'h0);

    // back-to-back 0x00 then 0xFF
    valid_cyc_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, k);
    send_frame(8'hFF, 1'b1, k2);
    idle(4);
    check("b2b_valid_count", 32'(valid_cyc_q.size()), 32'd2);
    if (valid_cyc_q.size() == 2) check("b2b_spacing", 32'(valid_cyc_q[1] - valid_cyc_q[0]), 32'd160);
    check("b2b_last_data", 32'(data), 32'hFF);

    // glitch: 5 low cycles
    valid_cyc_q.delete();
    ferr_before = ferr_seen;
    busy_cnt = 0;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("glitch_busy_window", 32'(busy_cnt >= 1 && busy_cnt <= 10), 32'd1);
    check("glitch_no_valid", 32'(valid_cyc_q.size()), 32'd0);
    check("glitch_no_ferr", 32'(ferr_seen), 32'(ferr_before));
    check("glitch_idle", 32'(busy), 32'h0);

    // framing error after 0x99, then held-low break
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, k);
    exp_ferr = ferr_seen + 1;
    send_frame(8'hA5, 1'b0, k);
    low_busy_miss = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rx = 1'b0;
      if (!busy) low_busy_miss++;
    end
    check("ferr_one_pulse", 32'(ferr_seen), 32'(exp_ferr));
    check("ferr_data_kept", 32'(data), 32'h99);
    check("break_busy_held", 32'(low_busy_miss), 32'd0);
    idle(10);
    check("break_released", 32'(busy), 32'h0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, k);
    idle(4);
    check("after_break_data", 32'(data), 32'h3C);

    // mid-frame reset during data bit 4 of 0x12
    valid_cyc_q.delete();
    @(negedge clk);
    rx = 1'b0;
    repeat (N - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h12 >> i));
    @(negedge clk);
    rx = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    idle(200);
    check("midrst_no_valid", 32'(valid_cyc_q.size()), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, k);
    idle(4);
    check("midrst_next_data", 32'(data), 32'h5A);

    // random frames, some with a bad stop bit, random idle gaps
    for (int f = 0; f < 24; f++) begin
      b   = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 4) == 0);
      if (err) exp_ferr++;
      else exp_q.push_back(b);
      send_frame(b, !err, k);
      gap = err ? $urandom_range(4, 20) : $urandom_range(0, 20);
      idle(gap);
    end
    idle(40);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_ferr_count", 32'(ferr_seen), 32'(exp_ferr));
    check("final_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
